// File: rtl/fast_command_decoder.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// fast_command_decoder
// Receive end of the ETROC2 fast-command link. Raw 8-bit deserialized words of
// arbitrary bit phase are word-aligned on the idle code 8'hF0. The 10 legal
// codes are decoded back to 4-bit command IDs. The block produces command
// strobes, a bunch-crossing counter and a saturating link-error counter.
//
// Ports
//   clk40        in   40 MHz clock
//   rstn         in   synchronous active-low reset
//   din_i        in   [7:0] raw word, din_i[7] received first
//   realign_i    in   one-cycle pulse forcing the aligner back to SEARCH
//   clr_err_i    in   clear err_count_o (wins over a simultaneous increment)
//   locked_o     out  aligner is in LOCKED
//   phase_o      out  [2:0] selected bit offset inside {previous word, din}
//   cmd_o        out  [3:0] last decoded command ID
//   cmd_valid_o  out  strobe: legal non-idle code decoded while locked
//   l1a_o        out  strobe: L1A or L1A_BCR decoded while locked
//   bcr_o        out  strobe: BCR or L1A_BCR decoded while locked
//   illegal_o    out  strobe: code outside the legal set while locked
//   bc_count_o   out  [11:0] bunch-crossing counter, wraps BC_MAX->0
//   err_count_o  out  [15:0] saturating count of illegal codes while locked
// -----------------------------------------------------------------------------
module fast_command_decoder #(
  parameter int unsigned LOCK_COUNT   = 16,
  parameter int unsigned UNLOCK_COUNT = 4,
  parameter int unsigned BC_MAX       = 3563
) (
  input  logic        clk40,
  input  logic        rstn,
  input  logic [7:0]  din_i,
  input  logic        realign_i,
  input  logic        clr_err_i,
  output logic        locked_o,
  output logic [2:0]  phase_o,
  output logic [3:0]  cmd_o,
  output logic        cmd_valid_o,
  output logic        l1a_o,
  output logic        bcr_o,
  output logic        illegal_o,
  output logic [11:0] bc_count_o,
  output logic [15:0] err_count_o
);

  localparam int CNT_W = $clog2(LOCK_COUNT + 1);
  localparam int BAD_W = $clog2(UNLOCK_COUNT + 1);

  localparam logic [1:0] ST_SEARCH  = 2'd0;
  localparam logic [1:0] ST_CONFIRM = 2'd1;
  localparam logic [1:0] ST_LOCKED  = 2'd2;

  localparam logic [7:0]       IDLE_CODE    = 8'hF0;
  localparam logic [3:0]       CMD_BCR      = 4'd2;
  localparam logic [3:0]       CMD_L1A      = 4'd6;
  localparam logic [3:0]       CMD_L1A_BCR  = 4'd7;
  localparam logic [CNT_W-1:0] LOCK_CNT_MAX = CNT_W'(LOCK_COUNT);
  localparam logic [BAD_W-1:0] BAD_CNT_MAX  = BAD_W'(UNLOCK_COUNT);
  localparam logic [11:0]      BC_WRAP      = 12'(BC_MAX);

  // 8-bit candidate starting p bits into the 16-bit window (MSB first).
  function automatic logic [7:0] cand_at(input logic [15:0] w, input logic [2:0] p);
    case (p)
      3'd0:    cand_at = w[15:8];
      3'd1:    cand_at = w[14:7];
      3'd2:    cand_at = w[13:6];
      3'd3:    cand_at = w[12:5];
      3'd4:    cand_at = w[11:4];
      3'd5:    cand_at = w[10:3];
      3'd6:    cand_at = w[9:2];
      3'd7:    cand_at = w[8:1];
      default: cand_at = w[15:8];
    endcase
  endfunction

  // Returns {legal, id}; illegal codes return 5'b0_0000.
  function automatic logic [4:0] decode_code(input logic [7:0] code);
    case (code)
      8'hF0:   decode_code = {1'b1, 4'd0};
      8'h33:   decode_code = {1'b1, 4'd1};
      8'h5A:   decode_code = {1'b1, 4'd2};
      8'h55:   decode_code = {1'b1, 4'd3};
      8'h66:   decode_code = {1'b1, 4'd4};
      8'h69:   decode_code = {1'b1, 4'd5};
      8'h96:   decode_code = {1'b1, 4'd6};
      8'h99:   decode_code = {1'b1, 4'd7};
      8'hA5:   decode_code = {1'b1, 4'd8};
      8'hAA:   decode_code = {1'b1, 4'd9};
      default: decode_code = {1'b0, 4'd0};
    endcase
  endfunction

  logic [7:0]       prev_q;
  logic [1:0]       state_q,     state_d;
  logic [2:0]       phase_q,     phase_d;
  logic [CNT_W-1:0] cnt_q,       cnt_d;
  logic [BAD_W-1:0] bad_q,       bad_d;
  logic             locked_q,    locked_d;
  logic [3:0]       cmd_q,       cmd_d;
  logic             cmd_valid_q, cmd_valid_d;
  logic             l1a_q,       l1a_d;
  logic             bcr_q,       bcr_d;
  logic             illegal_q,   illegal_d;
  logic [11:0]      bc_q,        bc_d;
  logic [15:0]      err_q,       err_d;

  logic [15:0]      window_s;
  logic [7:0]       match_s;
  logic [2:0]       lowest_s;
  logic [7:0]       cand_s;
  logic             legal_s;
  logic [3:0]       id_s;
  logic [BAD_W-1:0] bad_inc_s;

  // Window, idle search over all offsets and decode at the selected offset.
  always_comb begin
    window_s = {prev_q, din_i};
    match_s  = 8'h00;
    for (int p = 0; p < 8; p++) begin
      match_s[3'(p)] = (cand_at(window_s, 3'(p)) == IDLE_CODE);
    end
    // Lowest matching offset wins.
    casez (match_s)
      8'b???????1: lowest_s = 3'd0;
      8'b??????10: lowest_s = 3'd1;
      8'b?????100: lowest_s = 3'd2;
      8'b????1000: lowest_s = 3'd3;
      8'b???10000: lowest_s = 3'd4;
      8'b??100000: lowest_s = 3'd5;
      8'b?1000000: lowest_s = 3'd6;
      8'b10000000: lowest_s = 3'd7;
      default:     lowest_s = 3'd0;
    endcase
    cand_s              = cand_at(window_s, phase_q);
    {legal_s, id_s}     = decode_code(cand_s);
    bad_inc_s           = bad_q + BAD_W'(1);
  end

  // Alignment FSM, command decode, error and bunch-crossing next state.
  always_comb begin
    state_d     = state_q;
    phase_d     = phase_q;
    cnt_d       = cnt_q;
    bad_d       = bad_q;
    cmd_d       = cmd_q;
    cmd_valid_d = 1'b0;
    l1a_d       = 1'b0;
    bcr_d       = 1'b0;
    illegal_d   = 1'b0;
    err_d       = err_q;
    case (state_q)
      ST_SEARCH: begin
        if (|match_s) begin
          phase_d = lowest_s;
          cnt_d   = CNT_W'(1);
          state_d = ST_CONFIRM;
        end else begin
          cnt_d = '0;
        end
      end
      ST_CONFIRM: begin
        if (legal_s) begin
          if (cnt_q == LOCK_CNT_MAX) begin
            state_d = ST_LOCKED;
            cnt_d   = '0;
            bad_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end else begin
          state_d = ST_SEARCH;
          cnt_d   = '0;
        end
      end
      ST_LOCKED: begin
        if (legal_s) begin
          cmd_d       = id_s;
          cmd_valid_d = (id_s != 4'd0);
          l1a_d       = (id_s == CMD_L1A) || (id_s == CMD_L1A_BCR);
          bcr_d       = (id_s == CMD_BCR) || (id_s == CMD_L1A_BCR);
          bad_d       = '0;
        end else begin
          illegal_d = 1'b1;
          err_d     = (err_q == 16'hFFFF) ? err_q : err_q + 16'd1;
          if (bad_inc_s == BAD_CNT_MAX) begin
            state_d = ST_SEARCH;
            bad_d   = '0;
          end else begin
            bad_d = bad_inc_s;
          end
        end
      end
      default: begin
        state_d = ST_SEARCH;
        cnt_d   = '0;
        bad_d   = '0;
      end
    endcase
    // realign beats every FSM transition; phase is left for the next idle match.
    if (realign_i) begin
      state_d = ST_SEARCH;
      cnt_d   = '0;
      bad_d   = '0;
    end else begin
      state_d = state_d;
    end
    if (clr_err_i) begin
      err_d = 16'h0000;
    end else begin
      err_d = err_d;
    end
    // A BCR strobe zeroes the counter on the same edge it is raised.
    if (bcr_d) begin
      bc_d = 12'd0;
    end else if (bc_q == BC_WRAP) begin
      bc_d = 12'd0;
    end else begin
      bc_d = bc_q + 12'd1;
    end
    locked_d = (state_d == ST_LOCKED);
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk40) begin
    if (!rstn) begin
      prev_q      <= 8'h00;
      state_q     <= ST_SEARCH;
      phase_q     <= 3'd0;
      cnt_q       <= '0;
      bad_q       <= '0;
      locked_q    <= 1'b0;
      cmd_q       <= 4'd0;
      cmd_valid_q <= 1'b0;
      l1a_q       <= 1'b0;
      bcr_q       <= 1'b0;
      illegal_q   <= 1'b0;
      bc_q        <= 12'd0;
      err_q       <= 16'h0000;
    end else begin
      prev_q      <= din_i;
      state_q     <= state_d;
      phase_q     <= phase_d;
      cnt_q       <= cnt_d;
      bad_q       <= bad_d;
      locked_q    <= locked_d;
      cmd_q       <= cmd_d;
      cmd_valid_q <= cmd_valid_d;
      l1a_q       <= l1a_d;
      bcr_q       <= bcr_d;
      illegal_q   <= illegal_d;
      bc_q        <= bc_d;
      err_q       <= err_d;
    end
  end

  assign locked_o    = locked_q;
  assign phase_o     = phase_q;
  assign cmd_o       = cmd_q;
  assign cmd_valid_o = cmd_valid_q;
  assign l1a_o       = l1a_q;
  assign bcr_o       = bcr_q;
  assign illegal_o   = illegal_q;
  assign bc_count_o  = bc_q;
  assign err_count_o = err_q;

endmodule
